crg_batch_ctrl: RTL and testbench
=================================

# crg_batch_ctrl

Parametrised batch controller for the correlated-random generator. It drives an external pipelined PRNG256-class core with key/prefix/counter, collects the valid outputs into an internal buffer, and exposes the buffer to the host-side UART controller for readout. Compared with the current fixed single-batch path, it adds:
- a variable batch length;
- N_CH independent prefix channels, each with a persistent per-channel counter, so nonces are never reused across batches;
- abort;
- valid-driven write addressing instead of a fixed latency offset.

## Interface
- DATA_W, 256: PRNG output word width and buffer word width.
- KEY_W, 128: key width.
- DEPTH, 256: buffer depth in words. Must be a power of 2, 2..4096.
- N_CH, 2: number of prefix channels, 1..128.
- CNT_W, 32: PRNG counter width.
- Derived constants: AW = $clog2(DEPTH); CW = max(1, $clog2(N_CH)).

- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- key_in  in  KEY_W  new key.
- key_we  in  1  key write strobe.
- start  in  1  batch start request.
- count  in  AW+1  requested number of words.
- ch_sel  in  CW  channel for the batch.
- abort  in  1  stop issuing requests.
- busy  out  1  batch in progress.
- done  out  1  one-cycle pulse when a batch ends.
- aborted  out  1  qualifies done: the batch ended by abort.
- rejected  out  1  one-cycle pulse when a start is refused.
- words  out  AW+1  words written by the last or current batch.
- prng_key  out  KEY_W  key to the PRNG.
- prng_prefix  out  7  prefix to the PRNG (latched ch_sel, zero-extended).
- prng_cnt  out  CNT_W  counter to the PRNG.
- prng_req  out  1  request strobe (PRNG Drdy).
- prng_dout  in  DATA_W  PRNG output word.
- prng_vld  in  1  PRNG output valid (PRNG Dvld).
- rd_en  in  1  buffer read enable.
- rd_addr  in  AW  buffer read address.
- rd_data  out  DATA_W  buffer read data.
- rd_vld  out  1  read data valid.

## Operation
State machine: IDLE, ISSUE, DRAIN, FIN.

- **IDLE**
  - key_we=1 loads the key register and clears every channel counter to 0.
  - start=1 latches ch_sel and n = min(count, DEPTH), then clears wr_ptr and words.
  - If ctr[ch] + n > 2^CNT_W − 1 (computed in CNT_W+1 bits), the start is refused: rejected pulses for one cycle and the state stays IDLE.
  - Otherwise the next state is ISSUE. If n = 0, the next state is FIN directly.
  - If start and key_we occur in the same cycle, key_we is applied first; the start then checks against the cleared counters.
- **ISSUE**
  - Each cycle: prng_req=1, prng_cnt=ctr[ch]; then ctr[ch]++, issued++, outstanding++.
  - When issued reaches n, the next state is DRAIN.
  - abort=1 suppresses the request in that cycle and moves to DRAIN with an abort flag set.
- **DRAIN**
  - No requests are issued.
  - When outstanding = 0, the next state is FIN.
  - abort has no further effect.
- **FIN**
  - done=1 for one cycle and busy=0.
  - aborted=1 in this cycle if the abort flag is set.
  - The next state is IDLE.
- **Write path (any state)**
  - On prng_vld=1 while busy: buf[wr_ptr] ← prng_dout, wr_ptr++, words++, outstanding−−.
  - prng_vld while not busy is dropped; no write and no counter change.
  - A request and a valid in the same cycle leave outstanding unchanged.
- **Key lock:** key_we while busy is ignored.
- **Channel counters:** ctr[ch] persists across batches. A counter consumed by an aborted request that was not issued is not consumed.
- **Reset:** during reset, busy, done, aborted, rejected, prng_req, rd_vld and words are 0; prng_key, prng_prefix, prng_cnt and the counters are 0; the state is IDLE. Buffer contents are undefined. Reset mid-batch discards the batch, and any later prng_vld is dropped.

## Timing
- A start accepted in cycle t gives busy=1 from t+1.
- prng_req is high in cycles t+1 .. t+n.
- With a PRNG latency of L, the last valid arrives at t+n+L; done pulses at t+n+L+1, with busy=0 in that same cycle.
- The next start is accepted at t+n+L+2.
- Reads: rd_en in cycle r gives rd_data and rd_vld=1 in cycle r+1. Reads are allowed in any state.
- If a read and a write hit the same address in the same cycle, the read returns the old data.
- words updates in the cycle after each write.

## Test plan
- **Basic batch:** key K, ch 0, count 4, PRNG model with L=10 → prng_cnt 0,1,2,3 on 4 consecutive cycles; done at t+15; words=4; reading addresses 0..3 returns the model outputs for counters 0..3.
- **Persistent counter:** a second ch 0 batch of count 3 → prng_cnt 4,5,6. A ch 1 batch → prng_cnt 0 with prng_prefix 1. key_we, then a ch 0 batch → prng_cnt restarts at 0.
- **Boundary counts:** count 0 → done at t+1 with no prng_req and words=0. count DEPTH+5 → exactly DEPTH requests, and buffer address DEPTH−1 holds the last word.
- **Abort:** count 200, abort at the 20th request cycle → 19 requests, aborted=1 with done, words=19; the next batch on that channel starts at prng_cnt 19.
- **Exhaustion:** with CNT_W=8, consume 250 counters on ch 0, then count 10 → rejected pulse, busy stays 0; count 5 is accepted.
- **Protocol edges:**
  - key_we while busy → ignored.
  - start while busy → ignored.
  - rst_n pulsed mid-ISSUE → all outputs 0 immediately; later prng_vld produces no writes and words stays 0.

Source files
------------

// File: rtl/crg_batch_ctrl.sv
// Batch controller for the correlated-random generator: issues counter-driven PRNG
// requests per prefix channel and collects the valid outputs into a readable buffer.
module crg_batch_ctrl #(
    parameter  int DATA_W = 256,
    parameter  int KEY_W  = 128,
    parameter  int DEPTH  = 256,
    parameter  int N_CH   = 2,
    parameter  int CNT_W  = 32,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              key_we,
    input  logic              start,
    input  logic [AW:0]       count,
    input  logic [CW-1:0]     ch_sel,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              rejected,
    output logic [AW:0]       words,
    output logic [KEY_W-1:0]  prng_key,
    output logic [6:0]        prng_prefix,
    output logic [CNT_W-1:0]  prng_cnt,
    output logic              prng_req,
    input  logic [DATA_W-1:0] prng_dout,
    input  logic              prng_vld,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_vld
);

    localparam int SW = ((CNT_W > AW + 1) ? CNT_W : AW + 1) + 1;
    localparam logic [AW:0]    ONE_W   = (AW+1)'(1);
    localparam logic [AW:0]    DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [SW-1:0]  CNT_MAX = SW'({CNT_W{1'b1}});

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_FIN} state_t;

    state_t             r_state;
    logic [KEY_W-1:0]   r_key;
    logic [CNT_W-1:0]   r_ctr [N_CH];
    logic [CW-1:0]      r_ch;
    logic [AW:0]        r_n;
    logic [AW:0]        r_issued;
    logic [AW:0]        r_outst;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW:0]        r_words;
    logic               r_abort;
    logic               r_req;
    logic               r_busy;
    logic               r_done;
    logic               r_aborted;
    logic               r_rejected;
    logic [6:0]         r_prefix;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_rd_vld;

    logic               w_req;
    logic               w_wr;
    logic [AW:0]        w_n;
    logic [CNT_W-1:0]   w_ctr_start;
    logic [SW-1:0]      w_sum;
    logic               w_exhaust;
    logic [AW:0]        w_outst_nxt;

    // A request already scheduled for this cycle is withdrawn combinationally by abort.
    assign w_req       = r_req & ~abort;
    assign w_wr        = prng_vld & r_busy;
    assign w_n         = (count > DEPTH_W) ? DEPTH_W : count;
    assign w_ctr_start = key_we ? {CNT_W{1'b0}} : r_ctr[ch_sel];
    assign w_sum       = SW'(w_ctr_start) + SW'(w_n);
    assign w_exhaust   = (w_sum > CNT_MAX);

    // Outstanding-request count after this cycle's request and write.
    always_comb begin
        w_outst_nxt = r_outst;
        if (w_req && !w_wr) begin
            w_outst_nxt = r_outst + ONE_W;
        end else if (!w_req && w_wr) begin
            w_outst_nxt = r_outst - ONE_W;
        end else begin
            w_outst_nxt = r_outst;
        end
    end

    // Batch FSM, channel counters and write-path bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_key      <= '0;
            for (int i = 0; i < N_CH; i++) r_ctr[i] <= '0;
            r_ch       <= '0;
            r_n        <= '0;
            r_issued   <= '0;
            r_outst    <= '0;
            r_wr_ptr   <= '0;
            r_words    <= '0;
            r_abort    <= 1'b0;
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_rejected <= 1'b0;
            r_prefix   <= 7'd0;
            r_cnt      <= '0;
            r_rd_vld   <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_rejected <= 1'b0;
            r_rd_vld   <= rd_en;
            r_outst    <= w_outst_nxt;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_words  <= r_words + ONE_W;
            end
            case (r_state)
                ST_IDLE: begin
                    if (key_we) begin
                        r_key <= key_in;
                        for (int i = 0; i < N_CH; i++) r_ctr[i] <= '0;
                    end
                    if (start) begin
                        if (w_exhaust) begin
                            r_rejected <= 1'b1;
                        end else begin
                            r_ch     <= ch_sel;
                            r_prefix <= 7'(ch_sel);
                            r_n      <= w_n;
                            r_issued <= '0;
                            r_abort  <= 1'b0;
                            r_wr_ptr <= '0;
                            r_words  <= '0;
                            r_cnt    <= w_ctr_start;
                            if (w_n == '0) begin
                                r_state <= ST_FIN;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_ISSUE;
                                r_busy  <= 1'b1;
                                r_req   <= 1'b1;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    if (abort) begin
                        r_req   <= 1'b0;
                        r_abort <= 1'b1;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_ctr[r_ch] <= r_ctr[r_ch] + CNT_W'(1);
                        r_cnt       <= r_ctr[r_ch] + CNT_W'(1);
                        r_issued    <= r_issued + ONE_W;
                        if ((r_issued + ONE_W) == r_n) begin
                            r_req   <= 1'b0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_req   <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_outst_nxt == '0) begin
                        r_state   <= ST_FIN;
                        r_done    <= 1'b1;
                        r_aborted <= r_abort;
                        r_busy    <= 1'b0;
                    end else begin
                        r_state   <= ST_DRAIN;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Buffer storage: read-before-write on an address collision.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= prng_dout;
        end
        if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign aborted     = r_aborted;
    assign rejected    = r_rejected;
    assign words       = r_words;
    assign prng_key    = r_key;
    assign prng_prefix = r_prefix;
    assign prng_cnt    = r_cnt;
    assign prng_req    = w_req;
    assign rd_data     = r_rd_data;
    assign rd_vld      = r_rd_vld;

endmodule

// File: tb/tb_crg_batch_ctrl.sv
// Self-checking bench for crg_batch_ctrl: pipelined PRNG stand-in with latency L,
// per-channel counter model and buffer model, directed plus randomized batches.
module tb_crg_batch_ctrl;

    localparam int DATA_W = 64;
    localparam int KEY_W  = 128;
    localparam int DEPTH  = 64;
    localparam int N_CH   = 2;
    localparam int CNT_W  = 8;
    localparam int AW     = 6;
    localparam int CW     = 1;
    localparam int L      = 10;
    localparam int CMAX   = 255;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [KEY_W-1:0]  key_in = '0;
    logic              key_we = 1'b0;
    logic              start = 1'b0;
    logic [AW:0]       count = '0;
    logic [CW-1:0]     ch_sel = '0;
    logic              abort = 1'b0;
    logic              busy, done, aborted, rejected;
    logic [AW:0]       words;
    logic [KEY_W-1:0]  prng_key;
    logic [6:0]        prng_prefix;
    logic [CNT_W-1:0]  prng_cnt;
    logic              prng_req;
    logic [DATA_W-1:0] prng_dout;
    logic              prng_vld;
    logic              rd_en = 1'b0;
    logic [AW-1:0]     rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_vld;

    crg_batch_ctrl #(
        .DATA_W(DATA_W), .KEY_W(KEY_W), .DEPTH(DEPTH), .N_CH(N_CH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_we(key_we), .start(start),
        .count(count), .ch_sel(ch_sel), .abort(abort), .busy(busy), .done(done),
        .aborted(aborted), .rejected(rejected), .words(words), .prng_key(prng_key),
        .prng_prefix(prng_prefix), .prng_cnt(prng_cnt), .prng_req(prng_req),
        .prng_dout(prng_dout), .prng_vld(prng_vld), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_vld(rd_vld)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [63:0] prng_f(input logic [127:0] k, input logic [6:0] p,
                                           input logic [7:0] c);
        logic [63:0] mix;
        mix = {49'd0, p, c} * 64'h9E3779B97F4A7C15;
        return k[63:0] ^ {k[95:64], k[127:96]} ^ mix;
    endfunction

    // PRNG stand-in: fixed latency L from request to valid output.
    logic [L:1]  pv = '0;
    logic [63:0] pd [L+1];
    always @(posedge clk) begin
        pv[1] <= prng_req;
        pd[1] <= prng_f(prng_key, prng_prefix, prng_cnt);
        for (int k = 2; k <= L; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
    end
    assign prng_vld  = pv[L];
    assign prng_dout = pd[L];

    logic [14:0] req_q [$];
    always @(posedge clk) begin
        if (prng_req === 1'b1) req_q.push_back({prng_prefix, prng_cnt});
    end

    logic [127:0] key_m;
    int           ctr_m [N_CH];
    logic [63:0]  exp_mem [DEPTH];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in = k;
        key_we = 1'b1;
        @(negedge clk);
        key_we = 1'b0;
        key_m  = k;
        for (int c = 0; c < N_CH; c++) ctr_m[c] = 0;
        chk("key_load", prng_key, k);
    endtask

    task automatic readback(input int nw);
        for (int i = 0; i < nw; i++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(i);
            @(negedge clk);
            rd_en   = 1'b0;
            chk("rd_vld", rd_vld, 1'b1);
            chk($sformatf("rd_data[%0d]", i), rd_data, exp_mem[i]);
        end
    endtask

    // Runs one batch from a negedge in IDLE; abort_at is the 1-based request cycle to abort in.
    task automatic do_batch(input int ch, input int cnt, input int abort_at, input bit pokes);
        int n, n_eff, base, done_k, exp_k;
        bit rej;
        n     = (cnt > DEPTH) ? DEPTH : cnt;
        base  = ctr_m[ch];
        rej   = (base + n) > CMAX;
        n_eff = (abort_at > 0 && abort_at <= n) ? abort_at - 1 : n;
        req_q.delete();
        start  = 1'b1;
        count  = (AW+1)'(cnt);
        ch_sel = CW'(ch);
        @(negedge clk);
        start = 1'b0;
        if (rej) begin
            chk("rejected", rejected, 1'b1);
            chk("rej_busy", busy, 1'b0);
            @(negedge clk);
            chk("rej_pulse", rejected, 1'b0);
            chk("rej_noreq", req_q.size(), 0);
            return;
        end
        done_k = 0;
        for (int k = 1; k <= 400 && done_k == 0; k++) begin
            if (k == 1) chk("busy_t1", busy, (n > 0));
            if (done === 1'b1) begin
                done_k = k;
            end else begin
                if (pokes && k == 2) begin
                    key_in = ~key_m; key_we = 1'b1; start = 1'b1; count = (AW+1)'(1);
                end
                if (pokes && k == 3) begin
                    key_we = 1'b0; start = 1'b0;
                end
                if (abort_at > 0 && k == abort_at) abort = 1'b1;
                if (abort_at > 0 && k == abort_at + 1) abort = 1'b0;
                @(negedge clk);
            end
        end
        exp_k = (n_eff == 0 && n == 0) ? 1 : n_eff + L + 1;
        chk("done_cycle", done_k, exp_k);
        chk("done_busy", busy, 1'b0);
        chk("aborted", aborted, (n_eff != n));
        chk("words", words, n_eff);
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
        chk("key_kept", prng_key, key_m);
        chk("req_count", req_q.size(), n_eff);
        for (int i = 0; i < n_eff && i < req_q.size(); i++) begin
            chk($sformatf("req_cnt[%0d]", i), req_q[i][7:0], (base + i) & CMAX);
            chk("req_prefix", req_q[i][14:8], ch);
        end
        for (int i = 0; i < n_eff; i++) exp_mem[i] = prng_f(key_m, 7'(ch), 8'(base + i));
        ctr_m[ch] = base + n_eff;
        readback(n_eff);
    endtask

    initial begin
        key_m = '0;
        for (int c = 0; c < N_CH; c++) ctr_m[c] = 0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_req", prng_req, 1'b0);
        chk("rst_words", words, 0);
        chk("rst_cnt", prng_cnt, 0);
        chk("rst_key", prng_key, 0);
        chk("rst_rdvld", rd_vld, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        load_key({$urandom, $urandom, $urandom, $urandom});
        do_batch(0, 4, 0, 1'b0);           // basic: counters 0..3, done at t+15
        do_batch(0, 3, 0, 1'b0);           // persistent: 4..6
        do_batch(1, 5, 0, 1'b0);           // other channel starts at 0
        load_key({$urandom, $urandom, $urandom, $urandom});
        do_batch(0, 4, 0, 1'b0);           // restart after key load
        do_batch(1, 0, 0, 1'b0);           // zero count
        do_batch(0, DEPTH + 5, 0, 1'b0);   // clipped to DEPTH
        do_batch(1, 60, 20, 1'b0);         // abort -> 19 requests
        do_batch(1, 3, 0, 1'b1);           // resumes at 19; key_we/start while busy ignored
        for (int r = 0; r < 4; r++) begin
            do_batch(int'($urandom_range(0, N_CH - 1)), int'($urandom_range(1, 16)), 0, 1'b0);
        end

        load_key({$urandom, $urandom, $urandom, $urandom});
        for (int r = 0; r < 3; r++) do_batch(0, DEPTH, 0, 1'b0);
        do_batch(0, 58, 0, 1'b0);          // counter at 250
        do_batch(0, 10, 0, 1'b0);          // refused
        do_batch(0, 5, 0, 1'b0);           // 250..254 accepted

        start = 1'b1; count = (AW+1)'(20); ch_sel = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_req", prng_req, 1'b0);
        chk("mid_rst_cnt", prng_cnt, 0);
        chk("mid_rst_key", prng_key, 0);
        chk("mid_rst_prefix", prng_prefix, 0);
        chk("mid_rst_words", words, 0);
        @(negedge clk);
        rst_n = 1'b1;
        key_m = '0;
        for (int c = 0; c < N_CH; c++) ctr_m[c] = 0;
        repeat (2 * L) @(negedge clk);
        chk("post_rst_words", words, 0);
        chk("post_rst_busy", busy, 1'b0);
        readback(5);                        // earlier contents not overwritten
        do_batch(0, 2, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
